// File: rtl/btn_press_ctrl_if.sv
// Button sequencer bus: sampled inputs from the debouncer/divider and
// classified press events towards the display logic.
interface btn_press_ctrl_if #(
  parameter int unsigned CNT_W = 8
);

  logic             tick;
  logic             btn_level;
  logic             short_pulse;
  logic             long_pulse;
  logic             repeat_pulse;
  logic             double_pulse;
  logic             pressed;
  logic [CNT_W-1:0] evt_count;

  // Stimulus / upstream side
  modport master (
    output tick,
    output btn_level,
    input  short_pulse,
    input  long_pulse,
    input  repeat_pulse,
    input  double_pulse,
    input  pressed,
    input  evt_count
  );

  // Sequencer side
  modport slave (
    input  tick,
    input  btn_level,
    output short_pulse,
    output long_pulse,
    output repeat_pulse,
    output double_pulse,
    output pressed,
    output evt_count
  );

endinterface

// File: rtl/btn_press_ctrl.sv
// Button press sequencer: classifies debounced presses into short, long,
// auto-repeat (and optionally double-click) events and counts them.
// All state moves on tick cycles only; every event output is registered and
// high for exactly the cycle after the deciding tick.
// Optional feature: define BTN_DBLCLK_EN to enable double-click detection
// (adds the GAP and PRESS2 states); the default build has no double-click.
module btn_press_ctrl #(
  parameter int unsigned LONG_TICKS   = 500,
  parameter int unsigned REPEAT_TICKS = 100,
  parameter int unsigned DBL_TICKS    = 250,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  btn_press_ctrl_if.slave  bus
);

  localparam int unsigned MAX_LR = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
  localparam int unsigned MAX_T  = (MAX_LR > DBL_TICKS) ? MAX_LR : DBL_TICKS;
  localparam int unsigned HOLD_W = $clog2(MAX_T + 1);

  // The press tick itself counts as the first held tick, so PRESS fires one
  // increment earlier than the states that start counting after entry.
  localparam logic [HOLD_W-1:0] LONG_THR = HOLD_W'(LONG_TICKS - 2);
  localparam logic [HOLD_W-1:0] REP_THR  = HOLD_W'(REPEAT_TICKS - 1);
`ifdef BTN_DBLCLK_EN
  localparam logic [HOLD_W-1:0] DBL_THR  = HOLD_W'(DBL_TICKS - 1);
`endif

`ifdef BTN_DBLCLK_EN
  typedef enum logic [2:0] {
    ARM    = 3'd0,
    IDLE   = 3'd1,
    PRESS  = 3'd2,
    LONG   = 3'd3,
    GAP    = 3'd4,
    PRESS2 = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    ARM    = 3'd0,
    IDLE   = 3'd1,
    PRESS  = 3'd2,
    LONG   = 3'd3
  } state_t;
`endif

  state_t            state_q;
  state_t            state_d;
  logic [HOLD_W-1:0] hold_q;
  logic [HOLD_W-1:0] hold_d;
  logic [CNT_W-1:0]  evt_q;
  logic [CNT_W-1:0]  evt_d;
  logic              short_q;
  logic              short_d;
  logic              long_q;
  logic              long_d;
  logic              rep_q;
  logic              rep_d;
  logic              pressed_q;
  logic              pressed_d;
`ifdef BTN_DBLCLK_EN
  logic              dbl_q;
  logic              dbl_d;
`endif

  // State and hold counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARM;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state, hold counter and event decisions, evaluated on ticks only
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    short_d = 1'b0;
    long_d  = 1'b0;
    rep_d   = 1'b0;
`ifdef BTN_DBLCLK_EN
    dbl_d   = 1'b0;
`endif
    if (bus.tick) begin
      case (state_q)
        ARM: begin
          // A button held through reset must be released before it counts
          if (!bus.btn_level) begin
            state_d = IDLE;
            hold_d  = '0;
          end
        end
        IDLE: begin
          hold_d = '0;
          if (bus.btn_level) begin
            state_d = PRESS;
          end
        end
        PRESS: begin
          if (!bus.btn_level) begin
            hold_d  = '0;
`ifdef BTN_DBLCLK_EN
            state_d = GAP;
`else
            state_d = IDLE;
            short_d = 1'b1;
`endif
          end else if (hold_q == LONG_THR) begin
            state_d = LONG;
            long_d  = 1'b1;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
        LONG: begin
          if (!bus.btn_level) begin
            state_d = IDLE;
            hold_d  = '0;
          end else if (hold_q == REP_THR) begin
            rep_d  = 1'b1;
            hold_d = '0;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
`ifdef BTN_DBLCLK_EN
        GAP: begin
          if (bus.btn_level) begin
            state_d = PRESS2;
            hold_d  = '0;
          end else if (hold_q == DBL_THR) begin
            state_d = IDLE;
            short_d = 1'b1;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
        PRESS2: begin
          if (!bus.btn_level) begin
            state_d = IDLE;
            dbl_d   = 1'b1;
            hold_d  = '0;
          end else if (hold_q == LONG_THR) begin
            // Long hold on the second click drops the first click
            state_d = LONG;
            long_d  = 1'b1;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
`endif
        default: begin
          state_d = ARM;
          hold_d  = '0;
        end
      endcase
    end
  end

  // Event counter and button-down flag follow the decisions above
  always_comb begin
    evt_d = evt_q;
    if (short_d || rep_d) begin
      evt_d = evt_q + CNT_W'(1);
    end
`ifdef BTN_DBLCLK_EN
    if (dbl_d) begin
      evt_d = evt_q + CNT_W'(2);
    end
    pressed_d = (state_d == PRESS) || (state_d == LONG) || (state_d == PRESS2);
`else
    pressed_d = (state_d == PRESS) || (state_d == LONG);
`endif
  end

  // Registered event pulses, counter and pressed flag
  always_ff @(posedge clk) begin
    if (rst) begin
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      rep_q     <= 1'b0;
      pressed_q <= 1'b0;
      evt_q     <= '0;
`ifdef BTN_DBLCLK_EN
      dbl_q     <= 1'b0;
`endif
    end else begin
      short_q   <= short_d;
      long_q    <= long_d;
      rep_q     <= rep_d;
      pressed_q <= pressed_d;
      evt_q     <= evt_d;
`ifdef BTN_DBLCLK_EN
      dbl_q     <= dbl_d;
`endif
    end
  end

  assign bus.short_pulse  = short_q;
  assign bus.long_pulse   = long_q;
  assign bus.repeat_pulse = rep_q;
  assign bus.pressed      = pressed_q;
  assign bus.evt_count    = evt_q;
`ifdef BTN_DBLCLK_EN
  assign bus.double_pulse = dbl_q;
`else
  assign bus.double_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_btn_press_ctrl.sv
// Directed bench for btn_press_ctrl with LONG=8, REPEAT=3, DBL=4, CNT_W=4
// and one tick every 4 clocks.
module tb_btn_press_ctrl;

  localparam int unsigned DBL = 4;

  logic clk;
  logic rst;

  btn_press_ctrl_if #(.CNT_W(4)) bus ();

  btn_press_ctrl #(
    .LONG_TICKS  (8),
    .REPEAT_TICKS(3),
    .DBL_TICKS   (DBL),
    .CNT_W       (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;
  int n_short;
  int n_long;
  int n_rep;
  int n_dbl;
  int n_multi;
  int n_stray;
  logic [3:0] last; // {double, repeat, long, short} seen the cycle after a tick

  task automatic clear_counts();
    n_short = 0; n_long = 0; n_rep = 0; n_dbl = 0; n_multi = 0; n_stray = 0;
  endtask

  // One tick period: drive level with tick, sample the decision, watch idle cycles
  task automatic step(input logic lvl);
    @(negedge clk);
    bus.tick      = 1'b1;
    bus.btn_level = lvl;
    @(negedge clk);
    bus.tick = 1'b0;
    last = {bus.double_pulse, bus.repeat_pulse, bus.long_pulse, bus.short_pulse};
    n_short += int'(last[0]);
    n_long  += int'(last[1]);
    n_rep   += int'(last[2]);
    n_dbl   += int'(last[3]);
    if ($countones(last) > 1) n_multi++;
    repeat (2) begin
      @(negedge clk);
      if ({bus.double_pulse, bus.repeat_pulse, bus.long_pulse, bus.short_pulse} != 4'b0000)
        n_stray++;
    end
  endtask

  // Release, plus the double-click gap when that feature is built in
  task automatic release_settle();
    step(1'b0);
`ifdef BTN_DBLCLK_EN
    repeat (DBL) step(1'b0);
`endif
  endtask

  task automatic apply_reset(input logic lvl);
    @(negedge clk);
    rst = 1'b1;
    bus.tick = 1'b0;
    bus.btn_level = lvl;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    clear_counts();
  endtask

  task automatic test_reset();
    apply_reset(1'b0);
    total++;
    if ({bus.double_pulse, bus.repeat_pulse, bus.long_pulse, bus.short_pulse} !== 4'b0000) begin
      bad++; $display("FAIL reset_pulses: got %b want 0000",
        {bus.double_pulse, bus.repeat_pulse, bus.long_pulse, bus.short_pulse});
    end
    total++;
    if (bus.evt_count !== 4'd0 || bus.pressed !== 1'b0) begin
      bad++; $display("FAIL reset_state: evt=%0d pressed=%b want 0/0", bus.evt_count, bus.pressed);
    end
  endtask

  task automatic test_short();
    apply_reset(1'b0);
    step(1'b0);
    step(1'b1);
    total++;
    if (bus.pressed !== 1'b1) begin
      bad++; $display("FAIL short_pressed: got %b want 1", bus.pressed);
    end
    step(1'b1);
    step(1'b1);
    step(1'b0);
`ifdef BTN_DBLCLK_EN
    total++;
    if (last !== 4'b0000) begin
      bad++; $display("FAIL short_gap_entry: got %b want 0000", last);
    end
    repeat (DBL) step(1'b0);
`endif
    total++;
    if (last !== 4'b0001) begin
      bad++; $display("FAIL short_timing: got %b want 0001", last);
    end
    total++;
    if (bus.evt_count !== 4'd1 || n_long != 0 || n_short != 1) begin
      bad++; $display("FAIL short_counts: evt=%0d long=%0d short=%0d want 1/0/1",
        bus.evt_count, n_long, n_short);
    end
    total++;
    if (bus.pressed !== 1'b0) begin
      bad++; $display("FAIL short_released: got %b want 0", bus.pressed);
    end
  endtask

  task automatic test_long_repeat();
    int long_at;
    int rep_at[$];
    apply_reset(1'b0);
    step(1'b0);
    long_at = 0;
    for (int i = 1; i <= 20; i++) begin
      step(1'b1);
      if (last[1]) long_at = i;
      if (last[2]) rep_at.push_back(i);
    end
    total++;
    if (long_at != 8) begin
      bad++; $display("FAIL long_timing: got tick %0d want 8", long_at);
    end
    total++;
    if (rep_at.size() != 4) begin
      bad++; $display("FAIL repeat_count: got %0d want 4", rep_at.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        total++;
        if (rep_at[k] != 11 + 3 * k) begin
          bad++; $display("FAIL repeat_timing%0d: got tick %0d want %0d", k, rep_at[k], 11 + 3 * k);
        end
      end
    end
    step(1'b0);
    total++;
    if (last !== 4'b0000 || bus.evt_count !== 4'd4) begin
      bad++; $display("FAIL long_release: pulses=%b evt=%0d want 0000/4", last, bus.evt_count);
    end
    repeat (DBL) step(1'b0);
    total++;
    if (n_short != 0 || n_long != 1 || bus.pressed !== 1'b0) begin
      bad++; $display("FAIL long_counts: short=%0d long=%0d pressed=%b want 0/1/0",
        n_short, n_long, bus.pressed);
    end
  endtask

  task automatic test_threshold_release();
    apply_reset(1'b0);
    step(1'b0);
    repeat (7) step(1'b1);
    release_settle();
    total++;
    if (n_long != 0 || n_short != 1 || bus.evt_count !== 4'd1) begin
      bad++; $display("FAIL thr_press: long=%0d short=%0d evt=%0d want 0/1/1",
        n_long, n_short, bus.evt_count);
    end
    apply_reset(1'b0);
    step(1'b0);
    repeat (10) step(1'b1);
    step(1'b0);
    repeat (DBL) step(1'b0);
    total++;
    if (n_long != 1 || n_rep != 0 || n_short != 0 || bus.evt_count !== 4'd0) begin
      bad++; $display("FAIL thr_long: long=%0d rep=%0d short=%0d evt=%0d want 1/0/0/0",
        n_long, n_rep, n_short, bus.evt_count);
    end
  endtask

  task automatic test_held_reset();
    apply_reset(1'b1);
    repeat (12) step(1'b1);
    total++;
    if (n_short + n_long + n_rep + n_dbl != 0 || bus.pressed !== 1'b0) begin
      bad++; $display("FAIL held_reset: events=%0d pressed=%b want 0/0",
        n_short + n_long + n_rep + n_dbl, bus.pressed);
    end
    step(1'b0);
    step(1'b1);
    step(1'b1);
    release_settle();
    total++;
    if (n_short != 1 || bus.evt_count !== 4'd1) begin
      bad++; $display("FAIL held_rearm: short=%0d evt=%0d want 1/1", n_short, bus.evt_count);
    end
    // Reset in the middle of a press drops that press
    repeat (5) step(1'b1);
    apply_reset(1'b0);
    repeat (6) step(1'b0);
    total++;
    if (n_short + n_long + n_dbl != 0 || bus.evt_count !== 4'd0) begin
      bad++; $display("FAIL mid_reset: events=%0d evt=%0d want 0/0",
        n_short + n_long + n_dbl, bus.evt_count);
    end
  endtask

  task automatic test_wrap();
    apply_reset(1'b0);
    step(1'b0);
    for (int k = 1; k <= 16; k++) begin
      step(1'b1);
      release_settle();
      if (k == 15) begin
        total++;
        if (bus.evt_count !== 4'd15) begin
          bad++; $display("FAIL wrap_top: got %0d want 15", bus.evt_count);
        end
      end
    end
    total++;
    if (bus.evt_count !== 4'd0 || n_short != 16) begin
      bad++; $display("FAIL wrap: evt=%0d short=%0d want 0/16", bus.evt_count, n_short);
    end
  endtask

  task automatic test_double();
    apply_reset(1'b0);
    step(1'b0);
    step(1'b1); step(1'b1);
    step(1'b0); step(1'b0);
    step(1'b1); step(1'b1);
    step(1'b0);
`ifdef BTN_DBLCLK_EN
    total++;
    if (last !== 4'b1000 || n_dbl != 1 || n_short != 0 || bus.evt_count !== 4'd2) begin
      bad++; $display("FAIL double: last=%b dbl=%0d short=%0d evt=%0d want 1000/1/0/2",
        last, n_dbl, n_short, bus.evt_count);
    end
`else
    total++;
    if (last !== 4'b0001 || n_dbl != 0 || n_short != 2 || bus.evt_count !== 4'd2) begin
      bad++; $display("FAIL double: last=%b dbl=%0d short=%0d evt=%0d want 0001/0/2/2",
        last, n_dbl, n_short, bus.evt_count);
    end
`endif
    clear_counts();
    step(1'b1); step(1'b1);
    step(1'b0);
`ifdef BTN_DBLCLK_EN
    repeat (DBL - 1) step(1'b0);
    total++;
    if (n_short != 0) begin
      bad++; $display("FAIL gap_early: short=%0d want 0", n_short);
    end
    step(1'b0);
    total++;
    if (last !== 4'b0001 || bus.evt_count !== 4'd3) begin
      bad++; $display("FAIL gap_short: last=%b evt=%0d want 0001/3", last, bus.evt_count);
    end
`else
    total++;
    if (last !== 4'b0001 || bus.evt_count !== 4'd3) begin
      bad++; $display("FAIL gap_short: last=%b evt=%0d want 0001/3", last, bus.evt_count);
    end
    repeat (DBL) step(1'b0);
    total++;
    if (n_short != 1) begin
      bad++; $display("FAIL gap_extra: short=%0d want 1", n_short);
    end
`endif
  endtask

  task automatic test_pulse_hygiene();
    apply_reset(1'b0);
    step(1'b0);
    repeat (14) step(1'b1);
    release_settle();
    step(1'b1);
    release_settle();
    total++;
    if (n_multi != 0 || n_stray != 0) begin
      bad++; $display("FAIL pulse_hygiene: multi=%0d stray=%0d want 0/0", n_multi, n_stray);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    bus.tick = 1'b0;
    bus.btn_level = 1'b0;
    last = 4'b0000;
    clear_counts();
    test_reset();
    test_short();
    test_long_repeat();
    test_threshold_release();
    test_held_reset();
    test_wrap();
    test_double();
    test_pulse_hygiene();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
